// File: rtl/bram_drain_if.sv
// Signal bundle between the drain engine, the BRAM matrix read ports and the
// memory-controller write-back FIFOs. The drain engine uses the master side.
interface bram_drain_if #(
    parameter int NUM_CH = 16,
    parameter int LANE_W = 9,
    parameter int ADDR_W = 6,
    parameter int DATA_W = 33
);
    logic                      start;
    logic [ADDR_W:0]           words;
    logic [NUM_CH-1:0]         rd_en;
    logic [NUM_CH*LANE_W-1:0]  rd_lane;
    logic [NUM_CH*ADDR_W-1:0]  rd_addr;
    logic [NUM_CH*DATA_W-1:0]  rd_data;
    logic [NUM_CH-1:0]         wbfifo_full;
    logic [NUM_CH-1:0]         wbfifo_push;
    logic [NUM_CH*DATA_W-1:0]  wbfifo_data;
    logic                      busy;
    logic                      done;
    logic                      err_unimpl;

    modport master (
        input  start, words, rd_data, wbfifo_full,
        output rd_en, rd_lane, rd_addr, wbfifo_push, wbfifo_data,
        output busy, done, err_unimpl
    );

    modport slave (
        output start, words, rd_data, wbfifo_full,
        input  rd_en, rd_lane, rd_addr, wbfifo_push, wbfifo_data,
        input  busy, done, err_unimpl
    );
endinterface

// File: rtl/bram_drain.sv
// Drains NUM_LANES BRAM lanes into NUM_CH write-back FIFOs. Channel c walks its
// lanes (c, c+NUM_CH, ...) word-major and pushes every word to its own FIFO.
module bram_drain #(
    parameter int NUM_LANES = 420,
    parameter int NUM_CH    = 16,
    parameter int LANE_W    = 9,
    parameter int ADDR_W    = 6,
    parameter int DATA_W    = 33
) (
    input  logic         clk,
    input  logic         r_reset,
    bram_drain_if.master bus
);
    localparam int              LW1       = LANE_W + 1;
    localparam logic [ADDR_W:0] WORDS_MAX = (ADDR_W+1)'(1 << ADDR_W);
    localparam logic [ADDR_W:0] WORDS_ONE = (ADDR_W+1)'(1);

    typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_FLUSH, ST_FIN} state_t;

    logic              busy_reg;
    logic              done_reg;
    logic              err_reg;
    logic [ADDR_W-1:0] words_last_reg;
    logic              start_ok;
    logic              accept;
    logic              all_fin;
    logic [NUM_CH-1:0] fin_cand;

    assign start_ok = (bus.words != '0) && (bus.words <= WORDS_MAX);
    assign accept   = bus.start && !busy_reg && start_ok;
    // A channel counts as finished once its last push is on the bus this cycle,
    // so done and the fall of busy land on the same edge.
    assign all_fin  = &fin_cand;

    always_ff @(posedge clk or posedge r_reset) begin
        if (r_reset) begin
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            err_reg        <= 1'b0;
            words_last_reg <= '0;
        end else begin
            done_reg <= all_fin;
            if (accept) begin
                busy_reg       <= 1'b1;
                words_last_reg <= ADDR_W'(bus.words - WORDS_ONE);
            end else if (all_fin) begin
                busy_reg <= 1'b0;
            end
            if (bus.start && !accept) begin
                err_reg <= 1'b1;
            end
        end
    end

    assign bus.busy       = busy_reg;
    assign bus.done       = done_reg;
    assign bus.err_unimpl = err_reg;

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        localparam logic [LANE_W-1:0] FIRST_LANE = LANE_W'(gi);

        state_t            state_reg;
        state_t            state_next;
        logic [LANE_W-1:0] lane_reg;
        logic [LANE_W-1:0] lane_next;
        logic [ADDR_W-1:0] addr_reg;
        logic [ADDR_W-1:0] addr_next;
        logic              push_reg;
        logic [LANE_W:0]   lane_step;
        logic              last_lane;
        logic              issue;
        logic              final_rd;

        // Extra bit keeps lane+NUM_CH from wrapping near the top lane.
        assign lane_step = {1'b0, lane_reg} + LW1'(NUM_CH);
        assign last_lane = lane_step >= LW1'(NUM_LANES);
        assign issue     = (state_reg == ST_READ) && !bus.wbfifo_full[gi];
        assign final_rd  = issue && last_lane && (addr_reg == words_last_reg);
        assign fin_cand[gi] = (state_reg == ST_FIN) ||
                              ((state_reg == ST_FLUSH) && push_reg);

        always_comb begin
            state_next = state_reg;
            lane_next  = lane_reg;
            addr_next  = addr_reg;
            case (state_reg)
                ST_IDLE: begin
                    if (accept) begin
                        state_next = ST_READ;
                        lane_next  = FIRST_LANE;
                        addr_next  = '0;
                    end
                end
                ST_READ: begin
                    if (issue) begin
                        if (last_lane) begin
                            lane_next = FIRST_LANE;
                            addr_next = addr_reg + ADDR_W'(1);
                        end else begin
                            lane_next = lane_step[LANE_W-1:0];
                        end
                        if (final_rd) begin
                            state_next = ST_FLUSH;
                        end
                    end
                end
                ST_FLUSH: begin
                    if (push_reg) begin
                        state_next = all_fin ? ST_IDLE : ST_FIN;
                    end
                end
                ST_FIN: begin
                    if (all_fin) begin
                        state_next = ST_IDLE;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end

        always_ff @(posedge clk or posedge r_reset) begin
            if (r_reset) begin
                state_reg <= ST_IDLE;
                lane_reg  <= '0;
                addr_reg  <= '0;
                push_reg  <= 1'b0;
            end else begin
                state_reg <= state_next;
                lane_reg  <= lane_next;
                addr_reg  <= addr_next;
                push_reg  <= issue;
            end
        end

        assign bus.rd_en[gi]                         = issue;
        assign bus.rd_lane[gi*LANE_W +: LANE_W]      = lane_reg;
        assign bus.rd_addr[gi*ADDR_W +: ADDR_W]      = addr_reg;
        assign bus.wbfifo_push[gi]                   = push_reg;
        // Read data arrives one cycle after rd_en, i.e. in the push cycle.
        assign bus.wbfifo_data[gi*DATA_W +: DATA_W]  =
            push_reg ? bus.rd_data[gi*DATA_W +: DATA_W] : '0;
    end
endmodule

// File: tb/tb_bram_drain.sv
// Randomized self-checking bench for bram_drain: BRAM read-port model, per-channel
// expected push queues and a per-cycle strobe/status model.
module tb_bram_drain;
    localparam int NUM_LANES = 420;
    localparam int NUM_CH    = 16;
    localparam int LANE_W    = 9;
    localparam int ADDR_W    = 6;
    localparam int DATA_W    = 33;
    localparam int SALT_W    = DATA_W - LANE_W - ADDR_W;

    logic clk;
    logic r_reset;

    bram_drain_if #(.NUM_CH(NUM_CH), .LANE_W(LANE_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    bram_drain #(
        .NUM_LANES(NUM_LANES), .NUM_CH(NUM_CH), .LANE_W(LANE_W),
        .ADDR_W(ADDR_W), .DATA_W(DATA_W)
    ) dut (
        .clk    (clk),
        .r_reset(r_reset),
        .bus    (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks;
    int n_fail;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h expected=0x%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model state ----------------
    logic [SALT_W-1:0] salt;
    logic [DATA_W-1:0] exp_q [NUM_CH][$];
    int                rem [NUM_CH];
    int                push_cnt [NUM_CH];
    int                last_lane [NUM_CH];
    int                last_addr [NUM_CH];
    int                push_total;
    int                done_count;
    int                last_done_cyc;
    int                cyc;
    int                t0;
    int                m_done_at;
    bit                m_busy;
    bit                m_err;
    logic [NUM_CH-1:0] exp_push_vec;

    function automatic logic [DATA_W-1:0] bram_word(input int l, input int a);
        return {salt, LANE_W'(l), ADDR_W'(a)};
    endfunction

    task automatic model_clear();
        for (int c = 0; c < NUM_CH; c++) begin
            exp_q[c].delete();
            rem[c]      = 0;
            push_cnt[c] = 0;
        end
        push_total   = 0;
        m_busy       = 1'b0;
        m_err        = 1'b0;
        m_done_at    = -1;
        exp_push_vec = '0;
    endtask

    // Per-cycle monitor: BRAM model, strobe model and scoreboard, sampled on negedge.
    initial begin : monitor
        logic [NUM_CH*DATA_W-1:0] pend;
        logic [NUM_CH-1:0]        exp_iss;
        logic [DATA_W-1:0]        got_d;
        logic [DATA_W-1:0]        exp_d;
        bit                       exp_done;
        bit                       all_zero;
        int                       w;
        int                       l;
        int                       a;
        bus.rd_data = '0;
        forever begin
            @(negedge clk);
            cyc++;
            pend = '0;
            if (r_reset) begin
                model_clear();
                check("rst_rd_en", 64'(bus.rd_en), 64'd0);
                check("rst_push", 64'(bus.wbfifo_push), 64'd0);
                check("rst_busy", 64'(bus.busy), 64'd0);
                check("rst_done", 64'(bus.done), 64'd0);
                check("rst_err", 64'(bus.err_unimpl), 64'd0);
                for (int c = 0; c < NUM_CH; c++)
                    pend[c*DATA_W +: DATA_W] = DATA_W'({$urandom, $urandom});
            end else begin
                exp_done = (m_done_at == cyc);
                if (exp_done) begin
                    m_busy    = 1'b0;
                    m_done_at = -1;
                end
                check("busy", 64'(bus.busy), 64'(m_busy));
                check("done", 64'(bus.done), 64'(exp_done));
                check("err_unimpl", 64'(bus.err_unimpl), 64'(m_err));
                if (bus.done) begin
                    done_count++;
                    last_done_cyc = cyc;
                end

                check("push_vec", 64'(bus.wbfifo_push), 64'(exp_push_vec));
                for (int c = 0; c < NUM_CH; c++) begin
                    if (bus.wbfifo_push[c]) begin
                        push_cnt[c]++;
                        push_total++;
                        if (exp_q[c].size() == 0) begin
                            check($sformatf("push_extra_ch%0d", c), 64'(bus.wbfifo_push[c]), 64'd0);
                        end else begin
                            got_d = bus.wbfifo_data[c*DATA_W +: DATA_W];
                            exp_d = exp_q[c].pop_front();
                            check($sformatf("push_data_ch%0d", c), 64'(got_d), 64'(exp_d));
                        end
                    end
                end

                exp_iss = '0;
                for (int c = 0; c < NUM_CH; c++)
                    if (m_busy && rem[c] > 0 && !bus.wbfifo_full[c]) exp_iss[c] = 1'b1;
                check("rd_en_vec", 64'(bus.rd_en), 64'(exp_iss));

                for (int c = 0; c < NUM_CH; c++) begin
                    if (bus.rd_en[c]) begin
                        l = int'(bus.rd_lane[c*LANE_W +: LANE_W]);
                        a = int'(bus.rd_addr[c*ADDR_W +: ADDR_W]);
                        last_lane[c] = l;
                        last_addr[c] = a;
                        pend[c*DATA_W +: DATA_W] = bram_word(l, a);
                    end else begin
                        pend[c*DATA_W +: DATA_W] = DATA_W'({$urandom, $urandom});
                    end
                end

                all_zero = 1'b1;
                for (int c = 0; c < NUM_CH; c++) begin
                    if (exp_iss[c]) rem[c]--;
                    if (rem[c] != 0) all_zero = 1'b0;
                end
                if (exp_iss != '0 && all_zero) m_done_at = cyc + 2;
                exp_push_vec = exp_iss;

                if (bus.start) begin
                    w = int'(bus.words);
                    if (!m_busy && w >= 1 && w <= 64) begin
                        m_busy     = 1'b1;
                        push_total = 0;
                        for (int c = 0; c < NUM_CH; c++) begin
                            exp_q[c].delete();
                            rem[c]       = 0;
                            push_cnt[c]  = 0;
                            last_lane[c] = -1;
                            last_addr[c] = -1;
                            for (int aa = 0; aa < w; aa++)
                                for (int ll = c; ll < NUM_LANES; ll += NUM_CH) begin
                                    exp_q[c].push_back(bram_word(ll, aa));
                                    rem[c]++;
                                end
                        end
                    end else begin
                        m_err = 1'b1;
                    end
                end
            end
            @(posedge clk);
            #1;
            bus.rd_data = pend;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input int w);
        tick();
        bus.start = 1'b1;
        bus.words = 7'(w);
        t0 = cyc + 1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input bit rnd, output int lat);
        int n0;
        int k;
        n0 = done_count;
        k  = 0;
        while (done_count == n0 && k < budget) begin
            tick();
            k++;
            if (rnd) bus.wbfifo_full = NUM_CH'($urandom & $urandom);
        end
        bus.wbfifo_full = '0;
        check("done_seen", 64'(done_count != n0), 64'd1);
        lat = (done_count != n0) ? (last_done_cyc - t0) : -1;
        $display("drain done latency=%0d pushes=%0d", lat, push_total);
    endtask

    task automatic do_reset();
        tick();
        r_reset = 1'b1;
        repeat (2) tick();
        r_reset = 1'b0;
        tick();
    endtask

    task automatic async_reset_check(input string tag);
        tick();
        #2;
        r_reset = 1'b1;
        #1;
        check({tag, "_rd_en"},   64'(bus.rd_en), 64'd0);
        check({tag, "_push"},    64'(bus.wbfifo_push), 64'd0);
        check({tag, "_busy"},    64'(bus.busy), 64'd0);
        check({tag, "_done"},    64'(bus.done), 64'd0);
        check({tag, "_err"},     64'(bus.err_unimpl), 64'd0);
        check({tag, "_rd_lane"}, 64'(bus.rd_lane[LANE_W-1:0]), 64'd0);
        repeat (2) tick();
        r_reset = 1'b0;
        tick();
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog expired checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    // ---------------- scenarios ----------------
    initial begin : stim
        int lat;
        int n;
        n_checks        = 0;
        n_fail          = 0;
        done_count      = 0;
        last_done_cyc   = -1;
        cyc             = 0;
        t0              = 0;
        salt            = SALT_W'($urandom);
        r_reset         = 1'b1;
        bus.start       = 1'b0;
        bus.words       = '0;
        bus.wbfifo_full = '0;
        model_clear();
        repeat (3) tick();
        r_reset = 1'b0;
        repeat (2) tick();

        async_reset_check("rst_idle");

        // words=1, no backpressure
        launch(1);
        wait_done(200, 1'b0, lat);
        check("lat_w1", 64'(lat), 64'd29);
        check("total_w1", 64'(push_total), 64'd420);
        check("ch0_cnt_w1", 64'(push_cnt[0]), 64'd27);
        check("ch15_cnt_w1", 64'(push_cnt[15]), 64'd26);
        check("ch0_last_lane_w1", 64'(last_lane[0]), 64'd416);
        check("ch15_last_lane_w1", 64'(last_lane[15]), 64'd415);
        repeat (3) tick();

        // words=2
        launch(2);
        wait_done(300, 1'b0, lat);
        check("lat_w2", 64'(lat), 64'd56);
        check("total_w2", 64'(push_total), 64'd840);
        check("ch3_cnt_w2", 64'(push_cnt[3]), 64'd54);
        check("ch3_last_lane_w2", 64'(last_lane[3]), 64'd419);
        check("ch3_last_addr_w2", 64'(last_addr[3]), 64'd1);

        // reset in the middle of a drain
        launch(3);
        repeat (20) tick();
        async_reset_check("rst_drain");
        repeat (10) tick();
        check("no_push_after_rst", 64'(push_total), 64'd0);

        // ch5 stalled for 10 cycles mid-drain
        launch(2);
        repeat (4) tick();
        bus.wbfifo_full[5] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("stall_rd_en5", 64'(bus.rd_en[5]), 64'd0);
            check("stall_lane5", 64'(bus.rd_lane[5*LANE_W +: LANE_W]), 64'd69);
            check("stall_addr5", 64'(bus.rd_addr[5*ADDR_W +: ADDR_W]), 64'd0);
        end
        bus.wbfifo_full[5] = 1'b0;
        wait_done(300, 1'b0, lat);
        check("lat_stall", 64'(lat), 64'd64);
        check("ch5_cnt_stall", 64'(push_cnt[5]), 64'd52);
        check("ch0_cnt_stall", 64'(push_cnt[0]), 64'd54);
        check("total_stall", 64'(push_total), 64'd840);

        // illegal starts
        launch(0);
        repeat (3) tick();
        check("err_w0", 64'(bus.err_unimpl), 64'd1);
        check("busy_w0", 64'(bus.busy), 64'd0);
        do_reset();
        check("err_cleared", 64'(bus.err_unimpl), 64'd0);
        launch(1);
        repeat (3) tick();
        bus.start = 1'b1;
        bus.words = 7'd5;
        tick();
        bus.start = 1'b0;
        wait_done(200, 1'b0, lat);
        check("lat_busy_start", 64'(lat), 64'd29);
        check("total_busy_start", 64'(push_total), 64'd420);
        check("err_busy_start", 64'(bus.err_unimpl), 64'd1);
        do_reset();

        // words=64 under random backpressure
        launch(64);
        wait_done(20000, 1'b1, lat);
        check("total_w64", 64'(push_total), 64'd26880);
        check("ch0_cnt_w64", 64'(push_cnt[0]), 64'd1728);
        check("ch15_cnt_w64", 64'(push_cnt[15]), 64'd1664);
        n = done_count;
        repeat (10) tick();
        check("single_done_w64", 64'(done_count), 64'(n));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
